// File: rtl/symbol_mapper_iq.sv
// ---------------------------------------------------------------------------
// symbol_mapper_iq
//   Serialises data bytes MSB-first into BPSK / QPSK / 16-QAM symbols and
//   maps each symbol to signed I/Q amplitudes for the IQ pulse shaper.
//
// Ports
//   i_clk       clock
//   i_reset     synchronous, active-high reset
//   i_valid     input byte valid
//   o_ready     mapper can accept a byte this cycle (combinational)
//   i_data      data byte, MSB transmitted first
//   i_mode      00 BPSK, 01 QPSK, 10 16-QAM, 11 treated as QPSK
//   o_valid     output symbol valid (registered)
//   i_ready     downstream accepts the presented symbol
//   o_sample_i  signed I amplitude
//   o_sample_q  signed Q amplitude
//   o_first     presented symbol is the first symbol of its byte
// ---------------------------------------------------------------------------
module symbol_mapper_iq #(
    parameter int OW  = 16,
    parameter int AMP = 12000
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [7:0]           i_data,
    input  logic [1:0]           i_mode,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic signed [OW-1:0] o_sample_i,
    output logic signed [OW-1:0] o_sample_q,
    output logic                 o_first
);

    localparam int L = AMP / 3;

    localparam logic signed [OW-1:0] POS_A = OW'(AMP);
    localparam logic signed [OW-1:0] NEG_A = -POS_A;
    localparam logic signed [OW-1:0] POS_L = OW'(L);
    localparam logic signed [OW-1:0] NEG_L = -POS_L;

    localparam logic [1:0] MODE_BPSK = 2'b00;
    localparam logic [1:0] MODE_QAM  = 2'b10;

    // Gray-coded 16-QAM axis levels indexed by the two axis bits:
    // 00 -> +A, 01 -> +L, 11 -> -L, 10 -> -A.
    logic signed [OW-1:0] level_lut [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_level
            assign level_lut[gi] = (gi == 0) ? POS_A :
                                   (gi == 1) ? POS_L :
                                   (gi == 3) ? NEG_L : NEG_A;
        end
    endgenerate

    // Registered state
    logic [7:0]           shift_reg,  shift_next;
    logic [3:0]           remain_reg, remain_next;   // symbols not yet presented
    logic [1:0]           mode_reg,   mode_next;
    logic                 valid_reg,  valid_next;
    logic                 first_reg,  first_next;
    logic signed [OW-1:0] samp_i_reg, samp_i_next;
    logic signed [OW-1:0] samp_q_reg, samp_q_next;

    // Source of the symbol about to be loaded: a freshly accepted byte maps
    // straight from i_data so its first symbol appears the next cycle.
    logic       accept;
    logic       advance;
    logic [7:0] src_bits;
    logic [1:0] src_mode;

    function automatic logic [7:0] shift_out(input logic [7:0] bits, input logic [1:0] mode);
        case (mode)
            MODE_BPSK: shift_out = {bits[6:0], 1'b0};
            MODE_QAM:  shift_out = {bits[3:0], 4'b0000};
            default:   shift_out = {bits[5:0], 2'b00};
        endcase
    endfunction

    function automatic logic [3:0] symbols_left(input logic [1:0] mode);
        // Symbols still to present after the first one of a byte.
        case (mode)
            MODE_BPSK: symbols_left = 4'd7;
            MODE_QAM:  symbols_left = 4'd1;
            default:   symbols_left = 4'd3;
        endcase
    endfunction

    assign o_ready  = (remain_reg == 4'd0) && (!valid_reg || i_ready);
    assign accept   = i_valid && o_ready;
    assign advance  = !valid_reg || i_ready;
    assign src_bits = accept ? i_data : shift_reg;
    assign src_mode = accept ? i_mode : mode_reg;

    always_comb begin
        shift_next  = shift_reg;
        remain_next = remain_reg;
        mode_next   = mode_reg;
        valid_next  = valid_reg;
        first_next  = first_reg;
        samp_i_next = samp_i_reg;
        samp_q_next = samp_q_reg;

        if (accept || (advance && remain_reg != 4'd0)) begin
            valid_next = 1'b1;
            shift_next = shift_out(src_bits, src_mode);
            case (src_mode)
                MODE_BPSK: begin
                    samp_i_next = src_bits[7] ? NEG_A : POS_A;
                    samp_q_next = '0;
                end
                MODE_QAM: begin
                    samp_i_next = level_lut[src_bits[7:6]];
                    samp_q_next = level_lut[src_bits[5:4]];
                end
                default: begin
                    samp_i_next = src_bits[7] ? NEG_A : POS_A;
                    samp_q_next = src_bits[6] ? NEG_A : POS_A;
                end
            endcase
            if (accept) begin
                mode_next   = i_mode;
                first_next  = 1'b1;
                remain_next = symbols_left(i_mode);
            end else begin
                first_next  = 1'b0;
                remain_next = remain_reg - 4'd1;
            end
        end else if (i_ready) begin
            // Presented symbol consumed and nothing pending behind it.
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            shift_reg  <= '0;
            remain_reg <= '0;
            mode_reg   <= '0;
            valid_reg  <= 1'b0;
            first_reg  <= 1'b0;
            samp_i_reg <= '0;
            samp_q_reg <= '0;
        end else begin
            shift_reg  <= shift_next;
            remain_reg <= remain_next;
            mode_reg   <= mode_next;
            valid_reg  <= valid_next;
            first_reg  <= first_next;
            samp_i_reg <= samp_i_next;
            samp_q_reg <= samp_q_next;
        end
    end

    assign o_valid    = valid_reg;
    assign o_first    = first_reg;
    assign o_sample_i = samp_i_reg;
    assign o_sample_q = samp_q_reg;

endmodule

// File: tb/tb_symbol_mapper_iq.sv
module tb_symbol_mapper_iq;

    localparam int OW = 16;

    logic                 i_clk = 1'b0;
    logic                 i_reset;
    logic                 i_valid;
    logic                 o_ready;
    logic [7:0]           i_data;
    logic [1:0]           i_mode;
    logic                 o_valid;
    logic                 i_ready;
    logic signed [OW-1:0] o_sample_i;
    logic signed [OW-1:0] o_sample_q;
    logic                 o_first;

    symbol_mapper_iq #(.OW(OW), .AMP(12000)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data     (i_data),
        .i_mode     (i_mode),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_sample_i (o_sample_i),
        .o_sample_q (o_sample_q),
        .o_first    (o_first)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic first;
        int   si;
        int   sq;
    } sym_t;

    sym_t exp_q[$];
    int   hs_cycles[$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk_eq(input string tag, input logic signed [31:0] obs,
                          input logic signed [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, want);
        end
    endtask

    function automatic int gray_level(input logic [1:0] g);
        case (g)
            2'b00:   return 12000;
            2'b01:   return 4000;
            2'b11:   return -4000;
            default: return -12000;
        endcase
    endfunction

    // Reference model: expands one byte into its expected symbols.
    task automatic push_expected(input logic [7:0] d, input logic [1:0] m);
        sym_t s;
        if (m == 2'b00) begin
            for (int k = 0; k < 8; k++) begin
                s.first = (k == 0);
                s.si    = d[7-k] ? -12000 : 12000;
                s.sq    = 0;
                exp_q.push_back(s);
            end
        end else if (m == 2'b10) begin
            s.first = 1'b1; s.si = gray_level(d[7:6]); s.sq = gray_level(d[5:4]);
            exp_q.push_back(s);
            s.first = 1'b0; s.si = gray_level(d[3:2]); s.sq = gray_level(d[1:0]);
            exp_q.push_back(s);
        end else begin
            for (int k = 0; k < 4; k++) begin
                s.first = (k == 0);
                s.si    = d[7-2*k] ? -12000 : 12000;
                s.sq    = d[6-2*k] ? -12000 : 12000;
                exp_q.push_back(s);
            end
        end
    endtask

    // Monitor: a handshake seen mid-cycle completes on the next rising edge.
    always @(negedge i_clk) begin
        if (!i_reset && o_valid && i_ready) begin
            hs_cycles.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk_eq("unexpected_symbol", 32'(o_sample_i), 32'sd99999);
            end else begin
                sym_t e;
                e = exp_q.pop_front();
                $display("symbol: I=%0d Q=%0d first=%0b (want I=%0d Q=%0d first=%0b)",
                         o_sample_i, o_sample_q, o_first, e.si, e.sq, e.first);
                chk_eq("sample_i", 32'(o_sample_i), e.si);
                chk_eq("sample_q", 32'(o_sample_q), e.sq);
                chk_eq("first", {31'd0, o_first}, {31'd0, e.first});
            end
        end
    end

    // Offer a byte, wait for acceptance, record its expected symbols.
    task automatic send_byte(input logic [7:0] d, input logic [1:0] m);
        bit done = 0;
        i_valid = 1'b1;
        i_data  = d;
        i_mode  = m;
        for (int t = 0; t < 50 && !done; t++) begin
            @(negedge i_clk);
            if (o_ready) begin
                push_expected(d, m);
                done = 1;
            end
            @(posedge i_clk);
            #1;
        end
        i_valid = 1'b0;
        if (!done) chk_eq("accept_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge i_clk);
        @(posedge i_clk);
        #1;
        chk_eq("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        int n_seen;
        i_reset = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        i_mode  = '0;
        i_ready = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        i_reset = 1'b0;

        // Reset state and idle
        @(negedge i_clk);
        chk_eq("rst_valid", {31'd0, o_valid}, 0);
        chk_eq("rst_ready", {31'd0, o_ready}, 1);
        chk_eq("rst_i", 32'(o_sample_i), 0);
        chk_eq("rst_q", 32'(o_sample_q), 0);
        chk_eq("rst_first", {31'd0, o_first}, 0);
        @(posedge i_clk);
        #1;

        // Main mappings
        send_byte(8'hA5, 2'b00);
        wait_drain();
        send_byte(8'h1B, 2'b01);
        wait_drain();
        send_byte(8'h3C, 2'b10);
        wait_drain();
        send_byte(8'h1B, 2'b11);
        wait_drain();

        // Backpressure: first symbol of 0xE4 is (-A,-A) with o_first
        i_ready = 1'b0;
        send_byte(8'hE4, 2'b01);
        for (int k = 0; k < 5; k++) begin
            @(negedge i_clk);
            chk_eq("bp_valid", {31'd0, o_valid}, 1);
            chk_eq("bp_i", 32'(o_sample_i), -12000);
            chk_eq("bp_q", 32'(o_sample_q), -12000);
            chk_eq("bp_first", {31'd0, o_first}, 1);
            chk_eq("bp_ready", {31'd0, o_ready}, 0);
            @(posedge i_clk);
            #1;
        end
        i_ready = 1'b1;
        wait_drain();

        // Throughput: two QPSK bytes back-to-back, no bubble
        hs_cycles.delete();
        send_byte(8'h00, 2'b01);
        send_byte(8'hFF, 2'b01);
        wait_drain();
        chk_eq("tput_count", hs_cycles.size(), 8);
        if (hs_cycles.size() == 8) begin
            for (int k = 1; k < 8; k++)
                chk_eq("tput_gap", hs_cycles[k] - hs_cycles[k-1], 1);
        end

        // Reset mid-byte discards residual symbols
        i_ready = 1'b0;
        send_byte(8'hA5, 2'b00);
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        exp_q.delete();
        @(negedge i_clk);
        chk_eq("midrst_valid", {31'd0, o_valid}, 0);
        chk_eq("midrst_ready", {31'd0, o_ready}, 1);
        i_ready = 1'b1;
        n_seen = 0;
        repeat (12) begin
            @(negedge i_clk);
            if (o_valid) n_seen++;
        end
        chk_eq("midrst_residual", n_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
